// File: rtl/shift_pkg.sv
// Shared constants, op encodings and FSM state type for the iterative shift sequencer.
// Pure declarations: no logic, no latency, no flow control.
package shift_pkg;
    localparam int XLEN = 32;
    localparam int SHW  = 5;

    localparam logic [1:0] OP_SLL = 2'b00;
    localparam logic [1:0] OP_SRL = 2'b01;
    localparam logic [1:0] OP_SRA = 2'b11;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;
endpackage

// File: rtl/shift_seq_ctrl_if.sv
// Request/result bundle between the ALU side (master) and the shift sequencer (slave).
// Latency/backpressure: none here; start_valid/ready and result_valid/ready carry the flow control.
interface shift_seq_ctrl_if;
    import shift_pkg::*;

    logic            start_valid;
    logic            start_ready;
    logic [1:0]      op;
    logic [XLEN-1:0] operand;
    logic [SHW-1:0]  shamt;
    logic [XLEN-1:0] result;
    logic            result_valid;
    logic            result_ready;
    logic            busy;

    modport slave (
        input  start_valid, op, operand, shamt, result_ready,
        output start_ready, result, result_valid, busy
    );

    modport master (
        output start_valid, op, operand, shamt, result_ready,
        input  start_ready, result, result_valid, busy
    );
endinterface

// File: rtl/shift_step.sv
// One shift step of acc (1 bit, or 4 bits when SHIFT4_EN is defined and step4_i is set).
// Combinational, zero latency; no backpressure.
module shift_step
    import shift_pkg::*;
(
    input  logic [XLEN-1:0] acc_i,
    input  logic [1:0]      op_i,
`ifdef SHIFT4_EN
    input  logic            step4_i,
`endif
    output logic [XLEN-1:0] acc_o
);
    logic fill;
    logic left;

    // op 2'b10 falls through to a logical right shift
    assign left = (op_i == OP_SLL);
    assign fill = (op_i == OP_SRA) ? acc_i[XLEN-1] : 1'b0;

`ifdef SHIFT4_EN
    always_comb begin
        acc_o = '0;
        if (step4_i) begin
            acc_o = left ? {acc_i[XLEN-5:0], 4'b0000} : {{4{fill}}, acc_i[XLEN-1:4]};
        end else begin
            acc_o = left ? {acc_i[XLEN-2:0], 1'b0} : {fill, acc_i[XLEN-1:1]};
        end
    end
`else
    assign acc_o = left ? {acc_i[XLEN-2:0], 1'b0} : {fill, acc_i[XLEN-1:1]};
`endif
endmodule

// File: rtl/shift_seq_ctrl.sv
// Iterative SLL/SRL/SRA sequencer; latency shamt+1 (SHIFT4_EN: 1+shamt/4+shamt%4) cycles.
// One request in flight; start_ready only in IDLE, result held in DONE until result_ready.
module shift_seq_ctrl
    import shift_pkg::*;
(
    input  logic           clk,
    input  logic           rst_n,
    shift_seq_ctrl_if.slave bus
);
    state_t          state_q, state_d;
    logic [XLEN-1:0] acc_q, acc_d;
    logic [SHW-1:0]  cnt_q, cnt_d;
    logic [1:0]      op_q, op_d;
    logic [XLEN-1:0] step_acc;
    logic [SHW-1:0]  step_amt;

`ifdef SHIFT4_EN
    logic use4;
    assign use4     = (cnt_q >= SHW'(4));
    assign step_amt = use4 ? SHW'(4) : SHW'(1);
`else
    assign step_amt = SHW'(1);
`endif

    shift_step u_step (
        .acc_i   (acc_q),
        .op_i    (op_q),
`ifdef SHIFT4_EN
        .step4_i (use4),
`endif
        .acc_o   (step_acc)
    );

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        op_d    = op_q;
        case (state_q)
            IDLE: begin
                if (bus.start_valid) begin
                    op_d    = bus.op;
                    acc_d   = bus.operand;
                    cnt_d   = bus.shamt;
                    state_d = (bus.shamt == '0) ? DONE : SHIFT;
                end
            end
            SHIFT: begin
                // step never exceeds cnt, so cnt lands exactly on zero
                acc_d = step_acc;
                cnt_d = cnt_q - step_amt;
                if (cnt_q == step_amt) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                if (bus.result_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            acc_q   <= '0;
            cnt_q   <= '0;
            op_q    <= OP_SLL;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            op_q    <= op_d;
        end
    end

    assign bus.start_ready  = (state_q == IDLE);
    assign bus.busy         = (state_q != IDLE);
    assign bus.result_valid = (state_q == DONE);
    assign bus.result       = acc_q;
endmodule

// File: tb/tb_shift_seq_ctrl.sv
// Randomized and directed bench for shift_seq_ctrl against a latency-countdown reference model.
module tb_shift_seq_ctrl;
    import shift_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    shift_seq_ctrl_if bus();

    shift_seq_ctrl dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h at %0t", name, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] ref_shift(input logic [1:0] o, input logic [31:0] a, input logic [4:0] s);
        case (o)
            2'b00:   return a << s;
            2'b11:   return $unsigned($signed(a) >>> s);
            default: return a >> s;
        endcase
    endfunction

    function automatic int ref_lat(input int s);
`ifdef SHIFT4_EN
        return 1 + s / 4 + s % 4;
`else
        return s + 1;
`endif
    endfunction

    // Reference model: busy for lat-1 edges before the result shows, then held until taken.
    bit          m_busy;
    int          m_wait;
    logic [31:0] m_res;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_busy = 1'b0;
            m_wait = 0;
            m_res  = '0;
        end else if (!m_busy) begin
            if (bus.start_valid) begin
                m_busy = 1'b1;
                m_wait = ref_lat(int'(bus.shamt)) - 1;
                m_res  = ref_shift(bus.op, bus.operand, bus.shamt);
            end
        end else if (m_wait > 0) begin
            m_wait--;
        end else if (bus.result_ready) begin
            m_busy = 1'b0;
        end
    end

    always @(negedge clk) begin
        if (rst_n) begin
            check("start_ready", 32'(bus.start_ready), 32'(!m_busy));
            check("busy", 32'(bus.busy), 32'(m_busy));
            check("result_valid", 32'(bus.result_valid), 32'(m_busy && m_wait == 0));
            if (m_busy && m_wait == 0) begin
                check("result", bus.result, m_res);
            end
        end
    end

    task automatic wait_valid(output int lat);
        lat = 1;
        while (!bus.result_valid && lat < 64) begin
            @(negedge clk);
            lat++;
        end
        if (!bus.result_valid) begin
            check("valid_timeout", 32'(bus.result_valid), 32'd1);
        end
    endtask

    task automatic run_txn(input logic [1:0] o, input logic [31:0] a, input logic [4:0] s,
                           input int stall, output logic [31:0] got, output int lat);
        int n;
        got = '0;
        lat = 0;
        @(negedge clk);
        n = 0;
        while (!bus.start_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!bus.start_ready) begin
            check("accept_timeout", 32'(bus.start_ready), 32'd1);
            return;
        end
        bus.start_valid  = 1'b1;
        bus.op           = o;
        bus.operand      = a;
        bus.shamt        = s;
        bus.result_ready = 1'b0;
        @(negedge clk);
        // scribble inputs after accept; the latched request must not see them
        bus.start_valid = 1'b0;
        bus.operand     = 32'hFFFF_FFFF;
        bus.shamt       = 5'($urandom);
        bus.op          = 2'($urandom);
        wait_valid(lat);
        if (!bus.result_valid) return;
        got = bus.result;
        repeat (stall) @(negedge clk);
        check("result_stable", bus.result, got);
        bus.result_ready = 1'b1;
        @(negedge clk);
        bus.result_ready = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    initial begin
        logic [31:0] res;
        int          lat;
        logic [1:0]  ro;
        logic [31:0] ra;
        logic [4:0]  rs;

        bus.start_valid  = 1'b0;
        bus.op           = 2'b00;
        bus.operand      = '0;
        bus.shamt        = '0;
        bus.result_ready = 1'b0;

        repeat (2) @(negedge clk);
        check("rst_start_ready", 32'(bus.start_ready), 32'd1);
        check("rst_busy", 32'(bus.busy), 32'd0);
        check("rst_result_valid", 32'(bus.result_valid), 32'd0);
        check("rst_result", bus.result, 32'h0);
        rst_n = 1'b1;

        run_txn(2'b00, 32'h0000_0001, 5'd31, 0, res, lat);
        check("sll31_res", res, 32'h8000_0000);
`ifdef SHIFT4_EN
        check("sll31_lat", 32'(lat), 32'd11);
`else
        check("sll31_lat", 32'(lat), 32'd32);
`endif

        run_txn(2'b11, 32'h8000_0000, 5'd4, 1, res, lat);
        check("sra4_res", res, 32'hF800_0000);
`ifdef SHIFT4_EN
        check("sra4_lat", 32'(lat), 32'd2);
`else
        check("sra4_lat", 32'(lat), 32'd5);
`endif
        run_txn(2'b01, 32'h8000_0000, 5'd4, 0, res, lat);
        check("srl4_res", res, 32'h0800_0000);
        run_txn(2'b10, 32'h8000_0000, 5'd4, 2, res, lat);
        check("op10_res", res, 32'h0800_0000);
        run_txn(2'b11, 32'h8000_0000, 5'd7, 0, res, lat);
        check("sra7_res", res, 32'hFF00_0000);

        for (int o = 0; o < 4; o++) begin
            run_txn(2'(o), 32'hDEAD_BEEF, 5'd0, 0, res, lat);
            check("sh0_res", res, 32'hDEAD_BEEF);
            check("sh0_lat", 32'(lat), 32'd1);
        end

        run_txn(2'b00, 32'h0000_0001, 5'd8, 0, res, lat);
        check("input_change_res", res, 32'h0000_0100);

        // shamt 0 with result_ready held high: exactly one DONE cycle
        @(negedge clk);
        bus.result_ready = 1'b1;
        bus.start_valid  = 1'b1;
        bus.op           = 2'b01;
        bus.operand      = 32'hDEAD_BEEF;
        bus.shamt        = 5'd0;
        @(negedge clk);
        bus.start_valid = 1'b0;
        check("one_done_valid", 32'(bus.result_valid), 32'd1);
        check("one_done_res", bus.result, 32'hDEAD_BEEF);
        check("one_done_rdy", 32'(bus.start_ready), 32'd0);
        @(negedge clk);
        check("one_done_after_rdy", 32'(bus.start_ready), 32'd1);
        check("one_done_after_vld", 32'(bus.result_valid), 32'd0);
        bus.result_ready = 1'b0;

        // backpressure with a pending request held on start_valid
        @(negedge clk);
        bus.start_valid = 1'b1;
        bus.op          = 2'b00;
        bus.operand     = 32'h0000_0003;
        bus.shamt       = 5'd2;
        @(negedge clk);
        bus.start_valid = 1'b0;
        wait_valid(lat);
        check("bp_lat", 32'(lat), 32'd3);
        bus.start_valid = 1'b1;
        bus.op          = 2'b01;
        bus.operand     = 32'h0000_00F0;
        bus.shamt       = 5'd4;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("bp_start_ready", 32'(bus.start_ready), 32'd0);
            check("bp_valid", 32'(bus.result_valid), 32'd1);
            check("bp_res", bus.result, 32'h0000_000C);
        end
        bus.result_ready = 1'b1;
        @(negedge clk);
        bus.result_ready = 1'b0;
        check("bp_idle_ready", 32'(bus.start_ready), 32'd1);
        @(negedge clk);
        bus.start_valid = 1'b0;
        check("bp_next_accepted", 32'(bus.busy), 32'd1);
        wait_valid(lat);
        check("bp_next_res", bus.result, 32'h0000_000F);
        bus.result_ready = 1'b1;
        @(negedge clk);
        bus.result_ready = 1'b0;

        // asynchronous reset in the middle of a long shift
        @(negedge clk);
        bus.start_valid = 1'b1;
        bus.op          = 2'b11;
        bus.operand     = 32'h8765_4321;
        bus.shamt       = 5'd20;
        @(negedge clk);
        bus.start_valid = 1'b0;
        repeat (2) @(negedge clk);
        check("mid_busy", 32'(bus.busy), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check("arst_start_ready", 32'(bus.start_ready), 32'd1);
        check("arst_busy", 32'(bus.busy), 32'd0);
        check("arst_valid", 32'(bus.result_valid), 32'd0);
        check("arst_result", bus.result, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        run_txn(2'b00, 32'h0000_0003, 5'd2, 0, res, lat);
        check("post_rst_res", res, 32'h0000_000C);

        for (int i = 0; i < 40; i++) begin
            ro = 2'($urandom);
            ra = $urandom;
            rs = 5'($urandom);
            run_txn(ro, ra, rs, int'($urandom_range(0, 3)), res, lat);
            check("rand_res", res, ref_shift(ro, ra, rs));
            check("rand_lat", 32'(lat), 32'(ref_lat(int'(rs))));
        end

        repeat (2) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
